// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Supports stall (hold) and flush (bubble) and keeps a saturating count of bubbles entering EX.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic            reg_write_d,
    input  logic [1:0]      result_src_d,
    input  logic            mem_write_d,
    input  logic            jump_d,
    input  logic            branch_d,
    input  logic [2:0]      alu_control_d,
    input  logic            alu_src_d,
    output logic            valid_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic            reg_write_e,
    output logic [1:0]      result_src_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic [2:0]      alu_control_e,
    output logic            alu_src_e,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic bubble_in;

    // A stalled slot is not a new bubble; only flushes and invalid loads count.
    always_comb begin
        bubble_in = flush_e | (~stall_e & ~valid_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e       <= 1'b0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            imm_ext_e     <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            reg_write_e   <= 1'b0;
            result_src_e  <= '0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_control_e <= '0;
            alu_src_e     <= 1'b0;
            bubble_cnt    <= '0;
        end else begin
            if (bubble_in && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end

            if (flush_e) begin
                // Indices are zeroed too so forwarding sees x0 and never matches.
                valid_e       <= 1'b0;
                rd1_e         <= '0;
                rd2_e         <= '0;
                pc_e          <= '0;
                pc_plus4_e    <= '0;
                imm_ext_e     <= '0;
                rs1_e         <= '0;
                rs2_e         <= '0;
                rd_e          <= '0;
                reg_write_e   <= 1'b0;
                result_src_e  <= '0;
                mem_write_e   <= 1'b0;
                jump_e        <= 1'b0;
                branch_e      <= 1'b0;
                alu_control_e <= '0;
                alu_src_e     <= 1'b0;
            end else if (!stall_e) begin
                valid_e    <= valid_d;
                rd1_e      <= rd1_d;
                rd2_e      <= rd2_d;
                pc_e       <= pc_d;
                pc_plus4_e <= pc_plus4_d;
                imm_ext_e  <= imm_ext_d;
                rs1_e      <= rs1_d;
                rs2_e      <= rs2_d;
                rd_e       <= rd_d;
                // Control is gated so a non-instruction can never write state.
                if (valid_d) begin
                    reg_write_e   <= reg_write_d;
                    result_src_e  <= result_src_d;
                    mem_write_e   <= mem_write_d;
                    jump_e        <= jump_d;
                    branch_e      <= branch_d;
                    alu_control_e <= alu_control_d;
                    alu_src_e     <= alu_src_d;
                end else begin
                    reg_write_e   <= 1'b0;
                    result_src_e  <= '0;
                    mem_write_e   <= 1'b0;
                    jump_e        <= 1'b0;
                    branch_e      <= 1'b0;
                    alu_control_e <= '0;
                    alu_src_e     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed, table-driven bench for id_ex_pipe_reg (CNT_W=4 so saturation is reachable).
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, stall_e, flush_e, valid_d;
    logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]  result_src_d;
    logic [2:0]  alu_control_d;
    logic        valid_e;
    logic [31:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_control_e;
    logic [3:0]  bubble_cnt;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_write_d(mem_write_d),
        .jump_d(jump_d), .branch_d(branch_d), .alu_control_d(alu_control_d), .alu_src_d(alu_src_d),
        .valid_e(valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .branch_e(branch_e), .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
        .bubble_cnt(bubble_cnt)
    );

    // ctl packing: {reg_write, result_src[1:0], mem_write, jump, branch, alu_control[2:0], alu_src}
    typedef struct {
        bit          rst, stall, flush, valid;
        logic [31:0] rd1, imm;
        logic [4:0]  idx;
        logic [9:0]  ctl;
        bit          ev;
        logic [31:0] erd1, eimm;
        logic [4:0]  eidx;
        logic [9:0]  ectl;
        logic [3:0]  ebub;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // The other data/index inputs are rotations of rd1/imm/idx so every field is distinct yet 0 maps to 0.
    function automatic logic [159:0] data_of(input logic [31:0] rd1, input logic [31:0] imm);
        return {rd1, rotl(rd1, 8), rotl(imm, 12), rotl(imm, 20), imm};
    endfunction

    function automatic logic [14:0] idx_of(input logic [4:0] i);
        return {i[3:0], i[4], i[2:0], i[4:3], i};
    endfunction

    function automatic vec_t mk(input bit rst, input bit stall, input bit flush, input bit valid,
                                input logic [31:0] rd1, input logic [31:0] imm, input logic [4:0] idx,
                                input logic [9:0] ctl, input bit ev, input logic [31:0] erd1,
                                input logic [31:0] eimm, input logic [4:0] eidx, input logic [9:0] ectl,
                                input logic [3:0] ebub);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.valid = valid;
        v.rd1 = rd1; v.imm = imm; v.idx = idx; v.ctl = ctl;
        v.ev = ev; v.erd1 = erd1; v.eimm = eimm; v.eidx = eidx; v.ectl = ectl; v.ebub = ebub;
        return v;
    endfunction

    task automatic drive(input bit rst, input bit stall, input bit flush, input bit valid,
                         input logic [31:0] rd1, input logic [31:0] imm, input logic [4:0] idx,
                         input logic [9:0] ctl);
        logic [159:0] d;
        logic [14:0]  x;
        d = data_of(rd1, imm);
        x = idx_of(idx);
        reset = rst; stall_e = stall; flush_e = flush; valid_d = valid;
        {rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d} = d;
        {rs1_d, rs2_d, rd_d} = x;
        {reg_write_d, result_src_d, mem_write_d, jump_d, branch_d, alu_control_d, alu_src_d} = ctl;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input bit ev, input logic [31:0] erd1,
                               input logic [31:0] eimm, input logic [4:0] eidx,
                               input logic [9:0] ectl, input logic [3:0] ebub);
        chk({tag, ".valid"}, 160'(valid_e), 160'(ev));
        chk({tag, ".data"}, {rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e}, data_of(erd1, eimm));
        chk({tag, ".idx"}, 160'({rs1_e, rs2_e, rd_e}), 160'(idx_of(eidx)));
        chk({tag, ".ctl"}, 160'({reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
                                 alu_control_e, alu_src_e}), 160'(ectl));
        chk({tag, ".bubble_cnt"}, 160'(bubble_cnt), 160'(ebub));
    endtask

    initial begin
        //          rst st fl  v  rd1           imm           idx    ctl              ev erd1          eimm          eidx   ectl             bub
        vecs[0]  = mk(1, 0, 0, 1, 32'h0BADCAFE, 32'hFFFFF800, 5'd3,  10'b1000000000, 0, 32'h0,        32'h0,        5'd0,  10'b0000000000, 4'd0);
        vecs[1]  = mk(1, 1, 1, 1, 32'h0BADCAFE, 32'hFFFFF800, 5'd3,  10'b1000000000, 0, 32'h0,        32'h0,        5'd0,  10'b0000000000, 4'd0);
        vecs[2]  = mk(0, 0, 0, 1, 32'h11111111, 32'h00000FFC, 5'd5,  10'b1000000001, 1, 32'h11111111, 32'h00000FFC, 5'd5,  10'b1000000001, 4'd0);
        vecs[3]  = mk(0, 1, 0, 1, 32'hAAAA5555, 32'h12345678, 5'd9,  10'b1111111111, 1, 32'h11111111, 32'h00000FFC, 5'd5,  10'b1000000001, 4'd0);
        vecs[4]  = mk(0, 1, 0, 0, 32'hAAAA5555, 32'h12345678, 5'd9,  10'b1111111111, 1, 32'h11111111, 32'h00000FFC, 5'd5,  10'b1000000001, 4'd0);
        vecs[5]  = mk(0, 1, 0, 1, 32'hAAAA5555, 32'h12345678, 5'd9,  10'b1111111111, 1, 32'h11111111, 32'h00000FFC, 5'd5,  10'b1000000001, 4'd0);
        vecs[6]  = mk(0, 0, 0, 1, 32'hAAAA5555, 32'h12345678, 5'd9,  10'b1111111111, 1, 32'hAAAA5555, 32'h12345678, 5'd9,  10'b1111111111, 4'd0);
        vecs[7]  = mk(0, 1, 1, 1, 32'h76543210, 32'h0000ABCD, 5'd17, 10'b1010101010, 0, 32'h0,        32'h0,        5'd0,  10'b0000000000, 4'd1);
        vecs[8]  = mk(0, 0, 0, 0, 32'hDEADBEEF, 32'h00000100, 5'd7,  10'b1001000000, 0, 32'hDEADBEEF, 32'h00000100, 5'd7,  10'b0000000000, 4'd2);
        vecs[9]  = mk(0, 1, 0, 0, 32'hCAFEF00D, 32'h00000200, 5'd8,  10'b1111111111, 0, 32'hDEADBEEF, 32'h00000100, 5'd7,  10'b0000000000, 4'd2);
        vecs[10] = mk(0, 0, 0, 1, 32'h0BADF00D, 32'hFFFFFFF0, 5'd31, 10'b0110111011, 1, 32'h0BADF00D, 32'hFFFFFFF0, 5'd31, 10'b0110111011, 4'd2);
        vecs[11] = mk(1, 1, 0, 1, 32'h01234567, 32'h89ABCDEF, 5'd12, 10'b1111111111, 0, 32'h0,        32'h0,        5'd0,  10'b0000000000, 4'd0);
        vecs[12] = mk(0, 0, 0, 1, 32'h13579BDF, 32'h2468ACE0, 5'd3,  10'b1111111111, 1, 32'h13579BDF, 32'h2468ACE0, 5'd3,  10'b1111111111, 4'd0);

        drive(1, 0, 0, 0, '0, '0, '0, '0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].valid,
                  vecs[i].rd1, vecs[i].imm, vecs[i].idx, vecs[i].ctl);
            @(posedge clk);
            #1;
            chk_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erd1, vecs[i].eimm,
                        vecs[i].eidx, vecs[i].ectl, vecs[i].ebub);
        end

        // Saturation: 20 consecutive flushes, counter must stop at 15.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(0, 0, 1, 1, 32'h5A5A5A5A, 32'hA5A5A5A5, 5'd21, 10'b1111111111);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.bubble_cnt", i), 160'(bubble_cnt), 160'((i + 1 > 15) ? 15 : i + 1));
        end
        chk_outputs("sat_end", 0, 32'h0, 32'h0, 5'd0, 10'b0, 4'd15);

        // Reset asserted mid-flush clears the saturated counter.
        @(negedge clk);
        drive(1, 0, 1, 1, 32'h5A5A5A5A, 32'hA5A5A5A5, 5'd21, 10'b1111111111);
        @(posedge clk);
        #1;
        chk_outputs("sat_reset", 0, 32'h0, 32'h0, 5'd0, 10'b0, 4'd0);

        // First edge after reset deasserts loads normally.
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h0F0F0F0F, 32'h00000FFC, 5'd5, 10'b1000000001);
        @(posedge clk);
        #1;
        chk_outputs("post_reset", 1, 32'h0F0F0F0F, 32'h00000FFC, 5'd5, 10'b1000000001, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Pipeline register between Decode (ID) and Execute (EX) in the 5-stage RV32I core.
- Captures the decode-stage outputs: register-file read data, PC values, register indices, control bits, and the sign-extended immediate from the extender.
- Presents these values to EX one cycle later, with stall (hold) and flush (bubble insert) controls driven by the hazard unit.
- Maintains a saturating count of bubbles injected into EX, for performance debug.

Parameters:
- XLEN, 32, datapath width for data, PC and immediate fields.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_e  input  1  hold: EX register keeps its current contents.
- flush_e  input  1  insert bubble into EX next cycle.
- valid_d  input  1  ID holds a real instruction.
- rd1_d, rd2_d  input  XLEN each  register-file read data.
- pc_d, pc_plus4_d  input  XLEN each  instruction PC and PC+4.
- imm_ext_d  input  XLEN  extended immediate from the extender.
- rs1_d, rs2_d, rd_d  input  5 each  register indices.
- reg_write_d  input  1  control bit.
- result_src_d  input  2  control field.
- mem_write_d  input  1  control bit.
- jump_d  input  1  control bit.
- branch_d  input  1  control bit.
- alu_control_d  input  3  control field.
- alu_src_d  input  1  control bit.
- valid_e  output  1  EX holds a real instruction.
- rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e  output  XLEN each  registered copies of the _d inputs.
- rs1_e, rs2_e, rd_e  output  5 each  registered copies.
- reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_control_e, alu_src_e  output  as inputs  registered control.
- bubble_cnt  output  CNT_W  saturating count of bubbles entering EX.

Behaviour:
- Reset:
  - All outputs go to 0, including valid_e and bubble_cnt.
  - Reset takes effect on the edge where reset=1, and overrides stall_e and flush_e.
- Per-edge priority: reset > flush_e > stall_e > load.
- Flush (flush_e=1, reset=0):
  - Every _e output becomes 0, including the data fields and rs1_e/rs2_e/rd_e.
  - Zeroing the indices means the forwarding/hazard logic sees x0 and never matches.
  - Flush wins over a simultaneous stall_e=1.
- Stall (stall_e=1, flush_e=0): all _e outputs and valid_e hold their previous values.
- Load (stall_e=0, flush_e=0):
  - valid_e <= valid_d.
  - Data and index fields are captured unconditionally.
  - Control fields are captured only if valid_d=1; if valid_d=0 they are forced to 0, so a non-instruction can never write the register file or memory.
- Latency: exactly 1 cycle from _d inputs to _e outputs when not stalled.
- Bubble counter:
  - Increments by 1 on each edge where a bubble enters EX: (flush_e=1) or (load with valid_d=0).
  - Does not increment on stall (a stall does not create a new bubble).
  - Saturates at all-ones (2^CNT_W-1); no wrap-around.
  - Cleared only by reset.
- No combinational paths from inputs to outputs; every output is a flop.
- Reset asserted mid-stall or mid-flush: outputs are 0 on the next edge; normal loading resumes on the first edge after reset deasserts.

Test Plan:
- Reset: assert reset for 2 cycles with arbitrary inputs (imm_ext_d=0xFFFFF800, reg_write_d=1) -> all outputs 0, bubble_cnt=0.
- Load: valid_d=1, imm_ext_d=0x00000FFC, rd_d=5, reg_write_d=1, alu_src_d=1, no stall/flush -> next edge imm_ext_e=0x00000FFC, rd_e=5, reg_write_e=1, valid_e=1, bubble_cnt unchanged.
- Stall: after that load, hold stall_e=1 for 3 cycles while inputs change to imm_ext_d=0x12345678 -> imm_ext_e stays 0x00000FFC, valid_e=1, bubble_cnt unchanged; on release, 0x12345678 loads on the next edge.
- Flush over stall: assert stall_e=1 and flush_e=1 on the same edge with a valid instruction loaded -> all _e outputs 0, valid_e=0, bubble_cnt +1.
- Invalid load: valid_d=0, reg_write_d=1, mem_write_d=1, rd_d=7, rd1_d=0xDEADBEEF -> reg_write_e=0, mem_write_e=0, valid_e=0, rd_e=7, rd1_e=0xDEADBEEF, bubble_cnt +1.
- Saturation: with CNT_W=4, hold flush_e=1 for 20 cycles -> bubble_cnt reaches 15 and stays at 15; reset then returns it to 0.
